mem_access_ctrl: RTL and testbench

Data-bus access sequencer for the memory stage. It accepts one load or store per instruction and latches it. It drives the `dbus` request and holds it stable until `data_ok`, and stalls the pipeline in the meantime. It returns aligned, width-extended load data. It sits between the memory-stage logic and the `dbus_req_t`/`dbus_resp_t` port, and replaces direct combinational drive of `dreq`.

---
 rtl/common.sv | 39 +++
 rtl/mem_align.sv | 68 ++++++
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared bus types, memory-stage FSM states and funct3 encodings.
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: store shift/strobe, load extract/extend,
// natural-alignment check.
module mem_align
    import common::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [2:0]  i_addr_lo,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata_raw,
    output logic [7:0]  o_strobe,
    output msize_t      o_size,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata,
    output logic        o_misalign
);

    logic [5:0]  w_shamt;
    logic [63:0] w_t;
    logic [7:0]  w_mask;

    assign w_shamt  = {i_addr_lo, 3'b000};
    assign w_t      = i_rdata_raw >> w_shamt;
    assign o_wdata  = i_wdata << w_shamt;
    assign o_strobe = w_mask << i_addr_lo;

    always_comb begin
        o_size     = MSIZE1;
        w_mask     = 8'h01;
        o_misalign = 1'b0;
        unique case (i_funct3[1:0])
            2'd0: begin
                o_size = MSIZE1;
                w_mask = 8'h01;
            end
            2'd1: begin
                o_size     = MSIZE2;
                w_mask     = 8'h03;
                o_misalign = i_addr_lo[0];
            end
            2'd2: begin
                o_size     = MSIZE4;
                w_mask     = 8'h0F;
                o_misalign = |i_addr_lo[1:0];
            end
            2'd3: begin
                o_size     = MSIZE8;
                w_mask     = 8'hFF;
                o_misalign = |i_addr_lo;
            end
        endcase
    end

    // 3'b111 has no unsigned-double meaning; it falls through to the full double.
    always_comb begin
        o_rdata = w_t;
        case (i_funct3)
            F3_B:    o_rdata = {{56{w_t[7]}}, w_t[7:0]};
            F3_H:    o_rdata = {{48{w_t[15]}}, w_t[15:0]};
            F3_W:    o_rdata = {{32{w_t[31]}}, w_t[31:0]};
            F3_BU:   o_rdata = {56'd0, w_t[7:0]};
            F3_HU:   o_rdata = {48'd0, w_t[15:0]};
            F3_WU:   o_rdata = {32'd0, w_t[31:0]};
            F3_D:    o_rdata = w_t;
            default: o_rdata = w_t;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus sequencer: latches one load/store, holds dreq until data_ok,
// stalls the pipeline meanwhile and returns the extended load result.
module mem_access_ctrl
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic [63:0] rdata,
    output logic        done,
    output logic        misalign,
    output logic        stall
);

    mem_state_t  r_state;
    mem_state_t  w_next;
    logic [63:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_store;
    logic [63:0] r_wdata;
    logic        r_misalign;
    logic [63:0] r_rdata;

    logic        w_op;
    logic        w_idle;
    logic [2:0]  w_f3;
    logic [2:0]  w_addr_lo;
    logic [7:0]  w_strobe;
    msize_t      w_size;
    logic [63:0] w_wdata_sh;
    logic [63:0] w_rdata_ext;
    logic        w_misalign;
    logic        w_unused_addr_ok;

    assign w_op             = memread | memwrite;
    assign w_idle           = (r_state == IDLE);
    assign w_unused_addr_ok = dresp.addr_ok;

    // Live inputs feed the aligner while idle; the latched copy once the access is issued.
    assign w_f3      = w_idle ? funct3 : r_funct3;
    assign w_addr_lo = w_idle ? addr[2:0] : r_addr[2:0];

    mem_align u_align (
        .i_funct3    (w_f3),
        .i_addr_lo   (w_addr_lo),
        .i_wdata     (wdata),
        .i_rdata_raw (dresp.data),
        .o_strobe    (w_strobe),
        .o_size      (w_size),
        .o_wdata     (w_wdata_sh),
        .o_rdata     (w_rdata_ext),
        .o_misalign  (w_misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_funct3   <= '0;
            r_store    <= 1'b0;
            r_wdata    <= '0;
            r_misalign <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle && w_op) begin
                r_addr     <= addr;
                r_funct3   <= funct3;
                r_store    <= memwrite;
                r_wdata    <= w_wdata_sh;
                r_misalign <= w_misalign;
            end
            if (r_state == BUSY && dresp.data_ok && !r_store) begin
                r_rdata <= w_rdata_ext;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            IDLE: begin
                stall = w_op;
                if (w_op) begin
                    w_next = w_misalign ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dresp.data_ok) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request is a pure function of state and latched fields, so it cannot move mid-access.
    always_comb begin
        dreq = '0;
        if (r_state == BUSY) begin
            dreq.valid  = 1'b1;
            dreq.addr   = r_addr;
            dreq.size   = w_size;
            dreq.strobe = r_store ? w_strobe : 8'h00;
            dreq.data   = r_store ? r_wdata : 64'd0;
        end
    end

    assign done     = (r_state == DONE);
    assign misalign = done & r_misalign;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;
    import common::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic [63:0] rdata;
    logic        done;
    logic        misalign;
    logic        stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .memread  (memread),
        .memwrite (memwrite),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .dreq     (dreq),
        .dresp    (dresp),
        .rdata    (rdata),
        .done     (done),
        .misalign (misalign),
        .stall    (stall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (dreq !== '0) begin
            bad++;
            $display("FAIL reset_dreq: got %h want 0", dreq);
        end
        total++;
        if ({rdata, done, misalign, stall} !== {64'd0, 3'b000}) begin
            bad++;
            $display("FAIL reset_outs: got rdata=%h done=%b mis=%b stall=%b want all 0",
                     rdata, done, misalign, stall);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_aligned_store;
        tick();
        memwrite = 1'b1;
        funct3   = 3'b011;
        addr     = 64'h8000_0010;
        wdata    = 64'h1122_3344_5566_7788;
        #1;
        total++;
        if ({dreq.valid, stall, done} !== 3'b010) begin
            bad++;
            $display("FAIL sd_c1: got v/st/dn=%b%b%b want 010", dreq.valid, stall, done);
        end
        for (int c = 2; c <= 3; c++) begin
            tick();
            dresp.data_ok = (c == 3);
            #1;
            total++;
            if ({dreq.valid, stall, done} !== 3'b110) begin
                bad++;
                $display("FAIL sd_busy_c%0d: got v/st/dn=%b%b%b want 110", c, dreq.valid, stall,
                         done);
            end
            total++;
            if ({dreq.addr, dreq.size, dreq.strobe, dreq.data} !==
                {64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788}) begin
                bad++;
                $display("FAIL sd_req_c%0d: got a=%h sz=%0d st=%h d=%h", c, dreq.addr,
                         dreq.size, dreq.strobe, dreq.data);
            end
        end
        tick();
        dresp.data_ok = 1'b0;
        #1;
        total++;
        if ({dreq.valid, stall, done, misalign} !== 4'b0010) begin
            bad++;
            $display("FAIL sd_c4: got v/st/dn/mis=%b%b%b%b want 0010", dreq.valid, stall, done,
                     misalign);
        end
        total++;
        if (rdata !== 64'd0) begin
            bad++;
            $display("FAIL sd_rdata_kept: got %h want 0", rdata);
        end
        tick();
        memwrite = 1'b0;
        #1;
        total++;
        if ({done, stall} !== 2'b00) begin
            bad++;
            $display("FAIL sd_after: got dn/st=%b%b want 00", done, stall);
        end
    endtask

    task automatic test_byte_store;
        tick();
        memwrite = 1'b1;
        funct3   = 3'b000;
        addr     = 64'h8000_0003;
        wdata    = 64'h0000_0000_0000_00AB;
        #1;
        tick();
        dresp.data_ok = 1'b1;
        #1;
        total++;
        if ({dreq.valid, dreq.addr, dreq.size, dreq.strobe, dreq.data} !==
            {1'b1, 64'h8000_0003, MSIZE1, 8'h08, 64'h0000_0000_AB00_0000}) begin
            bad++;
            $display("FAIL sb_req: got v=%b a=%h sz=%0d st=%h d=%h", dreq.valid, dreq.addr,
                     dreq.size, dreq.strobe, dreq.data);
        end
        tick();
        dresp.data_ok = 1'b0;
        #1;
        total++;
        if ({done, dreq.valid} !== 2'b10) begin
            bad++;
            $display("FAIL sb_done: got dn/v=%b%b want 10", done, dreq.valid);
        end
        tick();
        memwrite = 1'b0;
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3  [7];
        logic [63:0] a   [7];
        logic [63:0] raw [7];
        logic [63:0] exp [7];
        msize_t      sz  [7];
        f3[0] = 3'b010; a[0] = 64'h8000_0004; raw[0] = 64'h8000_0000_0000_0000;
        exp[0] = 64'hFFFF_FFFF_8000_0000; sz[0] = MSIZE4;
        f3[1] = 3'b110; a[1] = 64'h8000_0004; raw[1] = 64'h8000_0000_0000_0000;
        exp[1] = 64'h0000_0000_8000_0000; sz[1] = MSIZE4;
        f3[2] = 3'b001; a[2] = 64'h8000_0006; raw[2] = 64'h8000_0000_0000_0000;
        exp[2] = 64'hFFFF_FFFF_FFFF_8000; sz[2] = MSIZE2;
        f3[3] = 3'b100; a[3] = 64'h8000_0007; raw[3] = 64'h8000_0000_0000_0000;
        exp[3] = 64'h0000_0000_0000_0080; sz[3] = MSIZE1;
        f3[4] = 3'b000; a[4] = 64'h8000_0007; raw[4] = 64'h8000_0000_0000_0000;
        exp[4] = 64'hFFFF_FFFF_FFFF_FF80; sz[4] = MSIZE1;
        f3[5] = 3'b111; a[5] = 64'h8000_0000; raw[5] = 64'h8000_0000_0000_0000;
        exp[5] = 64'h8000_0000_0000_0000; sz[5] = MSIZE8;
        f3[6] = 3'b101; a[6] = 64'h8000_0002; raw[6] = 64'h0000_0000_ABCD_0000;
        exp[6] = 64'h0000_0000_0000_ABCD; sz[6] = MSIZE2;
        for (int i = 0; i < 7; i++) begin
            tick();
            memread = 1'b1;
            funct3  = f3[i];
            addr    = a[i];
            #1;
            tick();
            dresp.data    = raw[i];
            dresp.data_ok = 1'b1;
            #1;
            total++;
            if ({dreq.valid, dreq.addr, dreq.size, dreq.strobe} !== {1'b1, a[i], sz[i], 8'h00})
            begin
                bad++;
                $display("FAIL ld%0d_req: got v=%b a=%h sz=%0d st=%h", i, dreq.valid, dreq.addr,
                         dreq.size, dreq.strobe);
            end
            tick();
            dresp.data_ok = 1'b0;
            #1;
            total++;
            if ({done, misalign, rdata} !== {2'b10, exp[i]}) begin
                bad++;
                $display("FAIL ld%0d_rdata: got dn=%b mis=%b rdata=%h want rdata=%h", i, done,
                         misalign, rdata, exp[i]);
            end
            tick();
            memread = 1'b0;
        end
    endtask

    task automatic test_misaligned;
        tick();
        memread = 1'b1;
        funct3  = 3'b010;
        addr    = 64'h8000_0002;
        #1;
        total++;
        if ({dreq.valid, stall, done} !== 3'b010) begin
            bad++;
            $display("FAIL mis_c1: got v/st/dn=%b%b%b want 010", dreq.valid, stall, done);
        end
        tick();
        #1;
        total++;
        if ({dreq.valid, stall, done, misalign} !== 4'b0011) begin
            bad++;
            $display("FAIL mis_c2: got v/st/dn/mis=%b%b%b%b want 0011", dreq.valid, stall, done,
                     misalign);
        end
        tick();
        memread = 1'b0;
        #1;
        total++;
        if ({dreq.valid, done, misalign, rdata} !== {3'b000, 64'h0000_0000_0000_ABCD}) begin
            bad++;
            $display("FAIL mis_c3: got v/dn/mis=%b%b%b rdata=%h want 000 rdata=abcd",
                     dreq.valid, done, misalign, rdata);
        end
    endtask

    task automatic test_reset_busy;
        tick();
        memread = 1'b1;
        funct3  = 3'b011;
        addr    = 64'h8000_0008;
        #1;
        tick();
        #1;
        total++;
        if (dreq.valid !== 1'b1) begin
            bad++;
            $display("FAIL rb_busy: got valid=%b want 1", dreq.valid);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (dreq.valid !== 1'b0) begin
            bad++;
            $display("FAIL rb_async_drop: got valid=%b want 0", dreq.valid);
        end
        memread = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        #1;
        total++;
        if ({dreq.valid, stall, done, rdata} !== {3'b000, 64'd0}) begin
            bad++;
            $display("FAIL rb_after: got v/st/dn=%b%b%b rdata=%h want 000 rdata=0", dreq.valid,
                     stall, done, rdata);
        end
    endtask

    task automatic test_back_to_back;
        tick();
        memwrite = 1'b1;
        funct3   = 3'b010;
        addr     = 64'h8000_0004;
        wdata    = 64'h0000_0000_DEAD_BEEF;
        #1;
        for (int c = 2; c <= 4; c++) begin
            tick();
            dresp.data_ok = (c == 4);
            if (c == 2) begin
                #1;
                total++;
                if ({dreq.valid, dreq.addr, dreq.size, dreq.strobe, dreq.data} !==
                    {1'b1, 64'h8000_0004, MSIZE4, 8'hF0, 64'hDEAD_BEEF_0000_0000}) begin
                    bad++;
                    $display("FAIL b2b_req_first: got v=%b a=%h sz=%0d st=%h d=%h", dreq.valid,
                             dreq.addr, dreq.size, dreq.strobe, dreq.data);
                end
            end
            addr   = 64'h1234_5670 + 64'(c);
            wdata  = {64{1'b1}} - 64'(c);
            funct3 = 3'(c);
            #1;
            total++;
            if ({dreq.valid, dreq.addr, dreq.size, dreq.strobe, dreq.data} !==
                {1'b1, 64'h8000_0004, MSIZE4, 8'hF0, 64'hDEAD_BEEF_0000_0000}) begin
                bad++;
                $display("FAIL b2b_stable_c%0d: got v=%b a=%h sz=%0d st=%h d=%h", c, dreq.valid,
                         dreq.addr, dreq.size, dreq.strobe, dreq.data);
            end
        end
        tick();
        dresp.data_ok = 1'b0;
        memwrite      = 1'b0;
        memread       = 1'b1;
        funct3        = 3'b011;
        addr          = 64'h8000_0020;
        #1;
        total++;
        if ({done, dreq.valid, stall} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_done: got dn/v/st=%b%b%b want 100", done, dreq.valid, stall);
        end
        tick();
        #1;
        total++;
        if ({done, dreq.valid, stall} !== 3'b001) begin
            bad++;
            $display("FAIL b2b_idle: got dn/v/st=%b%b%b want 001", done, dreq.valid, stall);
        end
        tick();
        dresp.data    = 64'h0123_4567_89AB_CDEF;
        dresp.data_ok = 1'b1;
        #1;
        total++;
        if ({dreq.valid, dreq.addr, dreq.size} !== {1'b1, 64'h8000_0020, MSIZE8}) begin
            bad++;
            $display("FAIL b2b_second_req: got v=%b a=%h sz=%0d", dreq.valid, dreq.addr,
                     dreq.size);
        end
        tick();
        dresp.data_ok = 1'b0;
        #1;
        total++;
        if ({done, rdata} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin
            bad++;
            $display("FAIL b2b_second_done: got dn=%b rdata=%h want 1 0123456789abcdef", done,
                     rdata);
        end
        tick();
        memread = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        memread  = 1'b0;
        memwrite = 1'b0;
        funct3   = 3'b000;
        addr     = '0;
        wdata    = '0;
        dresp    = '0;
        test_reset();
        test_aligned_store();
        test_byte_store();
        test_load_ext();
        test_misaligned();
        test_reset_busy();
        test_back_to_back();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish within 100000");
        $fatal(1, "timeout");
    end

endmodule
